dmem_burst_arbiter: RTL and testbench
=====================================

Name: dmem_burst_arbiter

Overview:
- Shares the single-port dmem between the processor and an auxiliary burst reader, e.g. the fetcher that refreshes the 12-word snake display buffer from data memory.
- Sits between the processor's dmem outputs and the dmem syncram, which is clocked on ~clock.
- The processor has priority. The aux side gets free cycles, and after STARVE_LIMIT consecutive blocked cycles it gets a forced slot (the processor is stalled for one cycle).
- The block sequences read-only bursts of up to MAX_LEN words and returns each word with its index.

Parameters:
- ADDR_W, 12, dmem address width.
- DATA_W, 32, dmem word width.
- LEN_W, 4, width of burst length and index.
- STARVE_LIMIT, 4, consecutive blocked aux cycles before a forced slot (must be ≥1).

Ports:
- clock  in  1  master clock (rising edge).
- reset  in  1  asynchronous, active-high reset.
- proc_access  in  1  processor uses dmem this cycle (load or store).
- proc_addr  in  ADDR_W  processor dmem address.
- proc_data  in  DATA_W  processor store data.
- proc_wren  in  1  processor write enable.
- proc_stall  out  1  processor must hold its dmem operation this cycle.
- aux_start  in  1  start burst (single-cycle pulse, sampled in IDLE only).
- aux_base  in  ADDR_W  burst base address, sampled with aux_start.
- aux_len  in  LEN_W  word count, sampled with aux_start.
- aux_busy  out  1  burst in progress.
- aux_valid  out  1  aux_rdata/aux_index valid this cycle.
- aux_index  out  LEN_W  word index within the burst (0-based).
- aux_rdata  out  DATA_W  word read.
- aux_done  out  1  one-cycle pulse after the last word (or after an empty burst).
- dmem_address  out  ADDR_W  to dmem.
- dmem_data  out  DATA_W  to dmem.
- dmem_wren  out  1  to dmem.
- dmem_q  in  DATA_W  from dmem.

Behaviour:
- **Reset** (asynchronous, any time, including mid-burst):
  - state=IDLE; the burst is abandoned and no done pulse is generated.
  - Counters cleared.
  - aux_busy, aux_valid, aux_done, proc_stall = 0; aux_index, aux_rdata = 0.
- **States:** IDLE, RUN, FIN.
  - IDLE: aux_start=1 latches base, len, idx=0.
    - len=0 → FIN.
    - len>0 → RUN.
  - RUN: on each grant, idx++. A grant of idx = len-1 → FIN.
  - FIN: aux_done=1 for one cycle → IDLE.
  - aux_start outside IDLE is ignored.
- **aux_busy** = (state != IDLE).
- **Arbitration** (RUN only):
  - force = (starve_cnt == STARVE_LIMIT).
  - grant = !proc_access || force.
  - proc_stall = force. It is derived only from registers; there is no combinational path from proc_* inputs.
- **starve_cnt:**
  - Increments each RUN cycle without a grant, saturating at STARVE_LIMIT.
  - Clears on grant and whenever state != RUN.
- **Mux:**
  - grant: dmem_address = base + idx (mod 2^ADDR_W, so wrap past 0xFFF goes to 0x000); dmem_wren = 0; dmem_data = proc_data (don't care).
  - Otherwise: dmem_address = proc_addr; dmem_data = proc_data; dmem_wren = proc_wren & proc_access.
  - In IDLE/FIN the processor always owns dmem.
- **Read latency:**
  - Because dmem captures on the falling edge, dmem_q is valid before the end of the grant cycle.
  - Grant in cycle t → aux_valid=1 in cycle t+1, with aux_rdata = dmem_q registered at the end of t and aux_index = idx used in t.
  - aux_valid is 0 when there is no grant. aux_rdata and aux_index hold their last values.
- **Done timing:** aux_done is asserted in the same cycle as the aux_valid of the last word (the FIN cycle). For len=0, aux_done is asserted the cycle after start, with no aux_valid.
- **Stalled processor write:** in a forced cycle, a processor store is not written; the processor must reissue it the next cycle.
- **Order:** words are delivered in strictly increasing index order, one per grant, never duplicated.

Test Plan:
- **Idle processor burst:** reset, proc_access=0; start base=0x010, len=12; dmem[0x010+i]=0x100+i → aux_valid on 12 consecutive cycles, index 0..11, data 0x100..0x10B. aux_done coincides with index 11. aux_busy falls the next cycle.
- **Starvation:** proc_access=1 continuously, STARVE_LIMIT=4, len=2 → proc_stall high exactly on the 5th and 10th RUN cycles. Each stall is followed by aux_valid; proc_stall never asserts on two consecutive cycles.
- **Address wrap and empty burst:** base=0xFFE, len=3 → dmem_address 0xFFE, 0xFFF, 0x000. A following start with len=0 → aux_done the next cycle with no aux_valid.
- **Write protection:** a processor store to 0x020 during a forced slot → dmem_wren=0 that cycle and dmem[0x020] is unchanged. A store on a non-forced cycle writes normally; aux_start while busy is ignored (burst length unchanged).
- **Reset mid-operation:** reset asserted mid-burst (index 5 of 12), between clock edges → all outputs 0 immediately. No aux_done; the next start runs cleanly from index 0.

Source files
------------

// File: rtl/dmem_burst_arbiter.sv
// Shares the single-port dmem between the processor (priority) and a read-only burst reader.
// The aux side takes idle cycles and, after STARVE_LIMIT blocked cycles, a forced slot that stalls the processor.
`timescale 1ns/1ps
module dmem_burst_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_proc_access,
  input  logic [ADDR_W-1:0] i_proc_addr,
  input  logic [DATA_W-1:0] i_proc_data,
  input  logic              i_proc_wren,
  output logic              o_proc_stall,
  input  logic              i_aux_start,
  input  logic [ADDR_W-1:0] i_aux_base,
  input  logic [LEN_W-1:0]  i_aux_len,
  output logic              o_aux_busy,
  output logic              o_aux_valid,
  output logic [LEN_W-1:0]  o_aux_index,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic              o_aux_done,
  output logic [ADDR_W-1:0] o_dmem_address,
  output logic [DATA_W-1:0] o_dmem_data,
  output logic              o_dmem_wren,
  input  logic [DATA_W-1:0] i_dmem_q
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [SC_W-1:0]   r_starve;
  logic              r_valid;
  logic [LEN_W-1:0]  r_index;
  logic [DATA_W-1:0] r_rdata;

  logic              w_run;
  logic              w_force;
  logic              w_grant;
  logic [ADDR_W-1:0] w_aux_addr;

  // Force depends only on registers, so the stall has no path from proc_* inputs.
  assign w_run      = (r_state == S_RUN);
  assign w_force    = w_run && (r_starve == SC_W'(STARVE_LIMIT));
  assign w_grant    = w_run && (!i_proc_access || w_force);
  assign w_aux_addr = r_base + ADDR_W'(r_idx);

  assign o_proc_stall = w_force;
  assign o_aux_busy   = (r_state != S_IDLE);
  assign o_aux_done   = (r_state == S_FIN);
  assign o_aux_valid  = r_valid;
  assign o_aux_index  = r_index;
  assign o_aux_rdata  = r_rdata;
  assign o_dmem_data  = i_proc_data;

  always_comb begin
    o_dmem_address = i_proc_addr;
    o_dmem_wren    = i_proc_wren & i_proc_access;
    if (w_grant) begin
      o_dmem_address = w_aux_addr;
      o_dmem_wren    = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_starve <= '0;
      r_valid  <= 1'b0;
      r_index  <= '0;
      r_rdata  <= '0;
    end else begin
      // dmem captures on the falling edge, so q is already valid at the end of the grant cycle.
      r_valid <= w_grant;
      if (w_grant) begin
        r_rdata <= i_dmem_q;
        r_index <= r_idx;
      end
      if (!w_run || w_grant)
        r_starve <= '0;
      else if (r_starve != SC_W'(STARVE_LIMIT))
        r_starve <= r_starve + SC_W'(1);
      case (r_state)
        S_IDLE: if (i_aux_start) begin
          r_base  <= i_aux_base;
          r_len   <= i_aux_len;
          r_idx   <= '0;
          r_state <= (i_aux_len == '0) ? S_FIN : S_RUN;
        end
        S_RUN: if (w_grant) begin
          r_idx <= r_idx + LEN_W'(1);
          if (r_idx == r_len - LEN_W'(1)) r_state <= S_FIN;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_burst_arbiter.sv
// Bench for dmem_burst_arbiter: falling-edge dmem model, expected-word scoreboard, directed and random bursts.
`timescale 1ns/1ps
module tb_dmem_burst_arbiter;
  localparam int AW = 12, DW = 32, LW = 4, SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_proc_access, i_proc_wren, i_aux_start;
  logic [AW-1:0] i_proc_addr, i_aux_base;
  logic [DW-1:0] i_proc_data;
  logic [LW-1:0] i_aux_len;
  logic          o_proc_stall, o_aux_busy, o_aux_valid, o_aux_done, o_dmem_wren;
  logic [LW-1:0] o_aux_index;
  logic [DW-1:0] o_aux_rdata, o_dmem_data, dmem_q;
  logic [AW-1:0] o_dmem_address;

  always #5 clk = ~clk;

  dmem_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_LIMIT(SL)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_proc_access(i_proc_access), .i_proc_addr(i_proc_addr), .i_proc_data(i_proc_data),
    .i_proc_wren(i_proc_wren), .o_proc_stall(o_proc_stall),
    .i_aux_start(i_aux_start), .i_aux_base(i_aux_base), .i_aux_len(i_aux_len),
    .o_aux_busy(o_aux_busy), .o_aux_valid(o_aux_valid), .o_aux_index(o_aux_index),
    .o_aux_rdata(o_aux_rdata), .o_aux_done(o_aux_done),
    .o_dmem_address(o_dmem_address), .o_dmem_data(o_dmem_data), .o_dmem_wren(o_dmem_wren),
    .i_dmem_q(dmem_q));

  typedef struct packed {
    logic          vld;
    logic          done;
    logic [LW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a >= 12'h010 && a <= 12'h01B) return 32'h100 + 32'(a - 12'h010);
    return {8'hA5, 12'h000, a};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // dmem syncram model clocked on ~clock (read-old-data)
  logic [DW-1:0] mem [0:4095];
  logic          mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 4096; a++) mem[a] <= init_val(AW'(a));
      mem_ready <= 1'b1;
    end else if (o_dmem_wren) begin
      mem[o_dmem_address] <= o_dmem_data;
    end
    dmem_q <= mem[o_dmem_address];
  end

  // Monitor: pops one expected entry per valid/done observation
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_proc_stall) check("stall_not_back_to_back", 32'(prev_stall), 32'd0);
      if (o_aux_valid || o_aux_done) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", {30'd0, o_aux_valid, o_aux_done}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("sb_valid", 32'(o_aux_valid), 32'(mon_e.vld));
          check("sb_done", 32'(o_aux_done), 32'(mon_e.done));
          if (mon_e.vld) begin
            check("sb_index", 32'(o_aux_index), 32'(mon_e.idx));
            check("sb_rdata", o_aux_rdata, mon_e.data);
          end
        end
      end
    end
    prev_stall <= rst ? 1'b0 : o_proc_stall;
  end

  logic [31:0]   stall_log;
  logic [AW-1:0] addr_log [0:31];
  int            nvalid_log, kdone;

  task automatic proc_idle();
    i_proc_access = 1'b0; i_proc_addr = '0; i_proc_wren = 1'b0; i_proc_data = '0;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l);
    i_aux_start = 1'b1; i_aux_base = b; i_aux_len = l;
    if (l == 0) sbq.push_back('{vld: 1'b0, done: 1'b1, idx: '0, data: '0});
    else for (int i = 0; i < int'(l); i++)
      sbq.push_back('{vld: 1'b1, done: (i == int'(l) - 1), idx: LW'(i), data: init_val(b + AW'(i))});
    @(posedge clk); #1;
    i_aux_start = 1'b0; i_aux_base = '0; i_aux_len = '0;
  endtask

  task automatic busy_falls(input string nm);
    @(posedge clk); #1;
    @(negedge clk);
    check(nm, 32'(o_aux_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  // Runs cycles after a start until aux_done, logging stall/address/valid per cycle
  task automatic run_burst(input int bound, input bit rnd);
    stall_log = '0; nvalid_log = 0; kdone = 0;
    for (int k = 1; k <= bound; k++) begin
      if (rnd) begin
        i_proc_access = ($urandom_range(0, 9) < 6);
        i_proc_addr   = 12'h800 | AW'($urandom_range(0, 255));
        i_proc_wren   = 1'($urandom_range(0, 1));
        i_proc_data   = $urandom;
      end
      @(negedge clk);
      if (k < 32) begin stall_log[k] = o_proc_stall; addr_log[k] = o_dmem_address; end
      if (o_aux_valid) nvalid_log++;
      if (o_aux_done) begin kdone = k; break; end
      @(posedge clk); #1;
    end
    check("burst_done_seen", 32'(kdone != 0), 32'd1);
    if (rnd) proc_idle();
    busy_falls("busy_after_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rb;
    logic [LW-1:0] rl;
    rst = 1'b1; proc_idle();
    i_aux_start = 1'b0; i_aux_base = '0; i_aux_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_aux_busy), 0);
    check("rst_valid", 32'(o_aux_valid), 0);
    check("rst_done", 32'(o_aux_done), 0);
    check("rst_stall", 32'(o_proc_stall), 0);
    check("rst_index", 32'(o_aux_index), 0);
    check("rst_rdata", o_aux_rdata, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Idle processor: 12 back-to-back words
    start_burst(12'h010, 4'd12);
    run_burst(40, 1'b0);
    check("t1_done_cycle", 32'(kdone), 13);
    check("t1_valid_count", 32'(nvalid_log), 12);

    // Continuous processor access: forced slots on RUN cycles 5 and 10
    i_proc_access = 1'b1; i_proc_addr = 12'h900;
    start_burst(12'h200, 4'd2);
    run_burst(40, 1'b0);
    check("t2_stall_mask", stall_log, 32'h0000_0420);
    check("t2_done_cycle", 32'(kdone), 11);
    proc_idle();

    // Address wrap, then empty burst
    start_burst(12'hFFE, 4'd3);
    run_burst(20, 1'b0);
    check("t3_addr0", 32'(addr_log[1]), 32'hFFE);
    check("t3_addr1", 32'(addr_log[2]), 32'hFFF);
    check("t3_addr2", 32'(addr_log[3]), 32'h000);
    start_burst(12'h100, 4'd0);
    run_burst(5, 1'b0);
    check("t3_empty_done_cycle", 32'(kdone), 1);
    check("t3_empty_no_valid", 32'(nvalid_log), 0);

    // Store blocked in forced slot, reissued store lands; start while busy ignored
    i_proc_access = 1'b1; i_proc_addr = 12'h900;
    start_burst(12'h300, 4'd2);
    kdone = 0;
    for (int k = 1; k <= 20; k++) begin
      i_aux_start = (k == 2); i_aux_base = 12'h500; i_aux_len = 4'd9;
      if (k == 5 || k == 6) begin
        i_proc_addr = 12'h020; i_proc_wren = 1'b1; i_proc_data = 32'hDEADBEEF;
      end else begin
        i_proc_addr = 12'h900; i_proc_wren = 1'b0;
      end
      @(negedge clk);
      if (k == 5) begin
        check("t4_forced_stall", 32'(o_proc_stall), 1);
        check("t4_forced_wren", 32'(o_dmem_wren), 0);
      end
      if (k == 6) begin
        check("t4_reissue_stall", 32'(o_proc_stall), 0);
        check("t4_reissue_wren", 32'(o_dmem_wren), 1);
        check("t4_reissue_addr", 32'(o_dmem_address), 32'h020);
      end
      if (o_aux_done) begin kdone = k; break; end
      @(posedge clk); #1;
      if (k == 5) check("t4_mem_unchanged", mem[12'h020], init_val(12'h020));
      if (k == 6) check("t4_mem_written", mem[12'h020], 32'hDEADBEEF);
    end
    i_aux_start = 1'b0; i_aux_base = '0; i_aux_len = '0;
    proc_idle();
    check("t4_done_cycle", 32'(kdone), 11);
    busy_falls("t4_busy_after_done");

    // Asynchronous reset mid-burst at index 5
    start_burst(12'h010, 4'd12);
    kdone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_aux_valid && o_aux_index == 4'd5) begin kdone = k; break; end
      @(posedge clk); #1;
    end
    check("t5_reached_index5", 32'(kdone), 7);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(o_aux_busy), 0);
    check("t5_rst_valid", 32'(o_aux_valid), 0);
    check("t5_rst_done", 32'(o_aux_done), 0);
    check("t5_rst_stall", 32'(o_proc_stall), 0);
    check("t5_rst_index", 32'(o_aux_index), 0);
    check("t5_rst_rdata", o_aux_rdata, 0);
    check("t5_rst_wren", 32'(o_dmem_wren), 0);
    check("t5_rst_addr", 32'(o_dmem_address), 0);
    sbq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done_after_reset", 32'(o_aux_done), 0);
    end
    @(posedge clk); #1;
    start_burst(12'h010, 4'd3);
    run_burst(20, 1'b0);
    check("t5_restart_done_cycle", 32'(kdone), 4);

    // Random bursts under random processor traffic
    repeat (25) begin
      rb = AW'($urandom_range(12'h100, 12'h7F0));
      rl = LW'($urandom_range(0, 15));
      start_burst(rb, rl);
      run_burst(100, 1'b1);
      check("rand_latency_bound",
            32'(kdone > 0 && kdone <= int'(rl) * (SL + 1) + 1), 32'd1);
      check("rand_valid_count", 32'(nvalid_log), 32'(rl));
    end

    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
